// File: rtl/smux_pkg.sv
// Shared types and constants for the SMUX round-robin arbiter slice.
package smux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } smux_state_t;

  typedef enum logic {
    REQ_B = 1'b0,
    REQ_A = 1'b1
  } smux_req_id_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/smux_if.sv
// Requester/consumer bundle for the SMUX arbiter; producers and consumer drive the master side.
interface smux_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  gnt_a, gnt_b, sel, out_valid, out_data
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, sel, out_valid, out_data
  );
endinterface

// File: rtl/smux_bus.sv
// Behavioural WIDTH-bit 2:1 select mux; sel = 1 routes a, sel = 0 routes b.
module smux_bus #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel
);

  always_comb begin
    out = sel ? a : b;
  end

endmodule

// File: rtl/smux_arbiter.sv
// Round-robin arbiter owning the select line of a shared 2:1 mux, with a per-tenure hold limit.
module smux_arbiter
  import smux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic   clk,
  input  logic   rst,
  smux_if.slave  bus
);

  localparam int              CW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD - 1);

  smux_state_t  state;
  smux_state_t  state_next;
  logic [CW-1:0] hold_cnt;
  smux_req_id_t last_gnt;
  logic         xfer;
  logic         tenure_end;
  logic         grant_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tenure_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          state_next = (last_gnt == REQ_B) ? GRANT_A : GRANT_B;
        end else if (bus.req_a) begin
          state_next = GRANT_A;
        end else if (bus.req_b) begin
          state_next = GRANT_B;
        end
      end
      GRANT_A: begin
        tenure_end = !bus.req_a || (xfer && (hold_cnt == HOLD_LAST));
        if (tenure_end) begin
          state_next = bus.req_b ? GRANT_B : (bus.req_a ? GRANT_A : IDLE);
        end
      end
      GRANT_B: begin
        tenure_end = !bus.req_b || (xfer && (hold_cnt == HOLD_LAST));
        if (tenure_end) begin
          state_next = bus.req_a ? GRANT_A : (bus.req_b ? GRANT_B : IDLE);
        end
      end
      default: state_next = IDLE;
    endcase
    // Re-entering the same grant after hold expiry counts as a fresh entry.
    grant_entry = (state_next != IDLE) && ((state_next != state) || tenure_end);
  end

  always_comb begin
    bus.gnt_a     = (state == GRANT_A);
    bus.gnt_b     = (state == GRANT_B);
    bus.sel       = (state == GRANT_A) ? SEL_A : SEL_B;
    bus.out_valid = ((state == GRANT_A) && bus.req_a) || ((state == GRANT_B) && bus.req_b);
  end

  assign xfer = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      last_gnt <= REQ_B;
    end else if (grant_entry) begin
      hold_cnt <= '0;
      last_gnt <= (state_next == GRANT_A) ? REQ_A : REQ_B;
    end else if (xfer) begin
      hold_cnt <= CW'(hold_cnt + 1'b1);
    end
  end

  smux_bus #(
    .WIDTH (WIDTH)
  ) u_bus (
    .out (bus.out_data),
    .a   (bus.data_a),
    .b   (bus.data_b),
    .sel (bus.sel)
  );

endmodule

// File: tb/tb_smux_arbiter.sv
// Directed and randomized checks of smux_arbiter against a grant-ownership reference model.
module tb_smux_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;

  smux_if #(.WIDTH(WIDTH)) bif ();

  smux_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the mux (0 none, 1 A, 2 B), transfers served this tenure, last owner.
  int owner;
  int served;
  int last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = 0;
    served = 0;
    last   = 2;
  endtask

  task automatic check_model(input string tag);
    logic ev;
    ev = (owner == 1 && bif.req_a) || (owner == 2 && bif.req_b);
    check({tag, ".gnt_a"},     {31'd0, bif.gnt_a},     {31'd0, owner == 1});
    check({tag, ".gnt_b"},     {31'd0, bif.gnt_b},     {31'd0, owner == 2});
    check({tag, ".sel"},       {31'd0, bif.sel},       {31'd0, owner == 1});
    check({tag, ".out_valid"}, {31'd0, bif.out_valid}, {31'd0, ev});
    check({tag, ".out_data"},  {24'd0, bif.out_data},  {24'd0, (owner == 1) ? bif.data_a : bif.data_b});
    check({tag, ".hold_cnt"},  {29'd0, dut.hold_cnt},  served);
  endtask

  // One clock: check outputs mid-low-phase, predict from the rules, commit at the rising edge.
  task automatic tick(input string tag);
    int n_owner, n_served, n_last;
    logic mine, other, xfer;
    #1;
    if (rst) model_reset();
    check_model(tag);
    n_owner = owner; n_served = served; n_last = last;
    if (rst) begin
      n_owner = 0; n_served = 0; n_last = 2;
    end else if (owner == 0) begin
      if (bif.req_a && bif.req_b) n_owner = (last == 2) ? 1 : 2;
      else if (bif.req_a)         n_owner = 1;
      else if (bif.req_b)         n_owner = 2;
      if (n_owner != 0) begin n_served = 0; n_last = n_owner; end
    end else begin
      mine  = (owner == 1) ? bif.req_a : bif.req_b;
      other = (owner == 1) ? bif.req_b : bif.req_a;
      xfer  = mine && bif.out_ready;
      if (!mine || (served + int'(xfer) == MAX_HOLD)) begin
        if (other)     n_owner = 3 - owner;
        else if (mine) n_owner = owner;
        else           n_owner = 0;
        if (n_owner != 0) begin n_served = 0; n_last = n_owner; end
      end else begin
        n_served = served + int'(xfer);
      end
    end
    @(posedge clk);
    owner = n_owner; served = n_served; last = n_last;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bif.req_a     = 1'b0;
    bif.req_b     = 1'b0;
    bif.data_a    = 8'h11;
    bif.data_b    = 8'h22;
    bif.out_ready = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset values against constants.
    #1;
    check("rst.gnt_a",     {31'd0, bif.gnt_a},     0);
    check("rst.gnt_b",     {31'd0, bif.gnt_b},     0);
    check("rst.sel",       {31'd0, bif.sel},       0);
    check("rst.out_valid", {31'd0, bif.out_valid}, 0);
    check("rst.out_data",  {24'd0, bif.out_data},  32'h22);
    do_reset();

    // A alone: one-cycle grant latency, continuous flow across hold re-entry.
    bif.req_a = 1'b1;
    tick("a_only.first");
    check("a_only.gnt_a", {31'd0, bif.gnt_a}, 1);
    for (int unsigned i = 0; i < 12; i++) begin
      check("a_only.flow", {31'd0, bif.out_valid}, 1);
      check("a_only.data", {24'd0, bif.out_data}, 32'h11);
      tick("a_only");
    end

    // Both requesting from reset: 4/4 alternation, A first.
    bif.req_a = 1'b0;
    do_reset();
    bif.req_a = 1'b1; bif.req_b = 1'b1;
    tick("both.first");
    check("both.a_first", {31'd0, bif.gnt_a}, 1);
    for (int unsigned i = 0; i < 4; i++) tick("both.a");
    check("both.b_next", {31'd0, bif.gnt_b}, 1);
    check("both.b_valid", {31'd0, bif.out_valid}, 1);
    for (int unsigned i = 0; i < 4; i++) tick("both.b");
    check("both.a_again", {31'd0, bif.gnt_a}, 1);
    for (int unsigned i = 0; i < 8; i++) tick("both.alt");

    // Stall during GRANT_B at hold_cnt 2.
    do_reset();
    bif.req_a = 1'b1; bif.req_b = 1'b1;
    for (int unsigned i = 0; i < 7; i++) tick("stall.pre");
    bif.out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check("stall.gnt_b",    {31'd0, bif.gnt_b},     1);
      check("stall.valid",    {31'd0, bif.out_valid}, 1);
      check("stall.hold_cnt", {29'd0, dut.hold_cnt},  2);
      tick("stall");
    end
    bif.out_ready = 1'b1;
    tick("stall.resume1");
    tick("stall.resume2");
    check("stall.switch_a", {31'd0, bif.gnt_a}, 1);

    // A drops after one transfer while B waits.
    do_reset();
    bif.req_a = 1'b1; bif.req_b = 1'b1;
    bif.data_a = 8'h5A; bif.data_b = 8'hC3;
    tick("drop.grant");
    tick("drop.xfer");
    bif.req_a = 1'b0;
    tick("drop.fall");
    check("drop.gnt_b",    {31'd0, bif.gnt_b},    1);
    check("drop.sel",      {31'd0, bif.sel},      0);
    check("drop.out_data", {24'd0, bif.out_data}, 32'hC3);
    tick("drop.b");

    // Asynchronous reset mid-GRANT_A.
    do_reset();
    bif.req_a = 1'b1; bif.req_b = 1'b0;
    tick("arst.grant");
    tick("arst.xfer");
    rst = 1'b1;
    #1;
    check("arst.gnt_a",     {31'd0, bif.gnt_a},     0);
    check("arst.out_valid", {31'd0, bif.out_valid}, 0);
    tick("arst.held");
    rst = 1'b0;
    bif.req_b = 1'b1;
    tick("arst.restart");
    check("arst.a_first", {31'd0, bif.gnt_a}, 1);

    // Randomized traffic, occasional resets.
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) bif.req_a = ~bif.req_a;
      if ($urandom_range(0, 4) == 0) bif.req_b = ~bif.req_b;
      bif.out_ready = ($urandom_range(0, 3) != 0);
      bif.data_a    = 8'($urandom);
      bif.data_b    = 8'($urandom);
      rst           = ($urandom_range(0, 99) == 0);
      tick("rand");
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
